param_processor: RTL



---
 rtl/proc_pkg.sv | 44 ++++
 rtl/param_alu.sv | 43 ++++
 rtl/param_processor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the parametrised accumulator processor: opcodes,
// FSM states and instruction field positions.
package proc_pkg;

    localparam int OPC_WIDTH = 4;

    localparam logic [OPC_WIDTH-1:0] OP_NOP   = 4'd0;
    localparam logic [OPC_WIDTH-1:0] OP_LDI   = 4'd1;
    localparam logic [OPC_WIDTH-1:0] OP_ADD   = 4'd2;
    localparam logic [OPC_WIDTH-1:0] OP_SUB   = 4'd3;
    localparam logic [OPC_WIDTH-1:0] OP_AND   = 4'd4;
    localparam logic [OPC_WIDTH-1:0] OP_OR    = 4'd5;
    localparam logic [OPC_WIDTH-1:0] OP_XOR   = 4'd6;
    localparam logic [OPC_WIDTH-1:0] OP_ADDAB = 4'd7;
    localparam logic [OPC_WIDTH-1:0] OP_JMP   = 4'd8;
    localparam logic [OPC_WIDTH-1:0] OP_JZ    = 4'd9;
    localparam logic [OPC_WIDTH-1:0] OP_JC    = 4'd10;
    localparam logic [OPC_WIDTH-1:0] OP_HALT  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Instruction layout is {opcode, B, A} with A in the low DATA_W bits.
    function automatic int field_a_lsb(input int data_w);
        return 0 * data_w;
    endfunction

    function automatic int field_b_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int field_op_lsb(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int instr_width(input int data_w, input int opc_w);
        return opc_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/param_alu.sv
// Combinational ALU for the accumulator processor; carry doubles as borrow on SUB.
module param_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]    a,
    input  logic [DATA_W-1:0]    b,
    input  logic [OPC_WIDTH-1:0] op,
    output logic [DATA_W-1:0]    result,
    output logic                 carry,
    output logic                 zero
);

    logic [DATA_W:0] ext;

    always_comb begin
        ext    = '0;
        result = a;
        carry  = 1'b0;
        case (op)
            OP_LDI: result = a;
            OP_ADD, OP_ADDAB: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[DATA_W-1:0];
                carry  = ext[DATA_W];
            end
            OP_SUB: begin
                // The ninth bit of a wrapped subtraction is exactly the borrow.
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[DATA_W-1:0];
                carry  = ext[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = a;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/param_processor.sv
// Accumulator processor with private program memory, PC, Z/C flags and jumps.
// Programs are loaded while idle or halted and run after a start pulse.
module param_processor
    import proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [OPC_W+2*DATA_W-1:0]   wr_data,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_W-1:0]           acc_out,
    output logic                        flag_z,
    output logic                        flag_c,
    output logic [ADDR_W-1:0]           pc_out
);

    localparam int INSTR_W = instr_width(DATA_W, OPC_W);
    localparam int A_LSB   = field_a_lsb(DATA_W);
    localparam int B_LSB   = field_b_lsb(DATA_W);
    localparam int OP_LSB  = field_op_lsb(DATA_W);

    logic [INSTR_W-1:0] mem [2**ADDR_W];
    logic [INSTR_W-1:0] ir;
    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic               z;
    logic               c;
    logic [ADDR_W-1:0]  pc;

    logic [OPC_W-1:0]   opc;
    logic [DATA_W-1:0]  fa;
    logic [DATA_W-1:0]  fb;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_r;
    logic               alu_c;
    logic               alu_z;
    logic               mem_we;

    assign opc = ir[OP_LSB +: OPC_W];
    assign fb  = ir[B_LSB +: DATA_W];
    assign fa  = ir[A_LSB +: DATA_W];

    // LDI and ADDAB work on the immediate A field; everything else on the accumulator.
    assign alu_a = (opc == OP_LDI || opc == OP_ADDAB) ? fa : acc;

    param_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (alu_a),
        .b      (fb),
        .op     (opc),
        .result (alu_r),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    assign mem_we = wr_en && (state == S_IDLE || state == S_HALT);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            acc   <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state <= S_FETCH;
                        pc    <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= mem[pc];
                    pc    <= pc + ADDR_W'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (opc)
                        OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDAB: begin
                            acc <= alu_r;
                            z   <= alu_z;
                            c   <= alu_c;
                        end
                        OP_JMP: pc <= fa[ADDR_W-1:0];
                        OP_JZ: begin
                            if (z) pc <= fa[ADDR_W-1:0];
                        end
                        OP_JC: begin
                            if (c) pc <= fa[ADDR_W-1:0];
                        end
                        OP_HALT: begin
                            state <= S_HALT;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign acc_out = acc;
    assign flag_z  = z;
    assign flag_c  = c;
    assign pc_out  = pc;

endmodule
